// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// axi_rd_arbiter : round-robin AR arbiter for two masters onto one slave
//                  read port, with R-burst routing back to the granted master.
// Revision 1.0
// ============================================================================
module axi_rd_arbiter #(
  parameter int ID_BITS   = 4,
  parameter int IDS_BITS  = 8,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3
) (
  input  logic                 AXI_CLK_i,
  input  logic                 AXI_RST_i,
  // master 0 AR
  input  logic [ID_BITS-1:0]   ARID_M0_i,
  input  logic [ADDR_BITS-1:0] ARADDR_M0_i,
  input  logic [LEN_BITS-1:0]  ARLEN_M0_i,
  input  logic [SIZE_BITS-1:0] ARSIZE_M0_i,
  input  logic [1:0]           ARBURST_M0_i,
  input  logic                 ARVALID_M0_i,
  output logic                 ARREADY_M0_o,
  // master 1 AR
  input  logic [ID_BITS-1:0]   ARID_M1_i,
  input  logic [ADDR_BITS-1:0] ARADDR_M1_i,
  input  logic [LEN_BITS-1:0]  ARLEN_M1_i,
  input  logic [SIZE_BITS-1:0] ARSIZE_M1_i,
  input  logic [1:0]           ARBURST_M1_i,
  input  logic                 ARVALID_M1_i,
  output logic                 ARREADY_M1_o,
  // master 0 R
  output logic [ID_BITS-1:0]   RID_M0_o,
  output logic [DATA_BITS-1:0] RDATA_M0_o,
  output logic [1:0]           RRESP_M0_o,
  output logic                 RLAST_M0_o,
  output logic                 RVALID_M0_o,
  input  logic                 RREADY_M0_i,
  // master 1 R
  output logic [ID_BITS-1:0]   RID_M1_o,
  output logic [DATA_BITS-1:0] RDATA_M1_o,
  output logic [1:0]           RRESP_M1_o,
  output logic                 RLAST_M1_o,
  output logic                 RVALID_M1_o,
  input  logic                 RREADY_M1_i,
  // slave AR
  output logic [IDS_BITS-1:0]  ARID_S_o,
  output logic [ADDR_BITS-1:0] ARADDR_S_o,
  output logic [LEN_BITS-1:0]  ARLEN_S_o,
  output logic [SIZE_BITS-1:0] ARSIZE_S_o,
  output logic [1:0]           ARBURST_S_o,
  output logic                 ARVALID_S_o,
  input  logic                 ARREADY_S_i,
  // slave R
  input  logic [IDS_BITS-1:0]  RID_S_i,
  input  logic [DATA_BITS-1:0] RDATA_S_i,
  input  logic [1:0]           RRESP_S_i,
  input  logic                 RLAST_S_i,
  input  logic                 RVALID_S_i,
  output logic                 RREADY_S_o,
  output logic                 ERR_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam int TAG_BITS = IDS_BITS - ID_BITS;

  state_t               state_q,   state_d;
  logic                 last_q,    last_d;
  logic                 grant_q,   grant_d;
  logic                 err_q,     err_d;
  logic                 arvalid_q, arvalid_d;
  logic [IDS_BITS-1:0]  arid_q,    arid_d;
  logic [ADDR_BITS-1:0] araddr_q,  araddr_d;
  logic [LEN_BITS-1:0]  arlen_q,   arlen_d;
  logic [SIZE_BITS-1:0] arsize_q,  arsize_d;
  logic [1:0]           arburst_q, arburst_d;
  logic [LEN_BITS-1:0]  beat_q,    beat_d;

  logic                 req_any;
  logic                 winner;
  logic                 in_data;
  logic                 rready_g;
  logic                 r_hs;
  logic [IDS_BITS-1:0]  tagged_id;
  logic [TAG_BITS-1:0]  grant_tag;

  assign req_any = ARVALID_M0_i | ARVALID_M1_i;
  // On a tie the master that was not served last wins; otherwise the sole requester.
  assign winner  = (ARVALID_M0_i & ARVALID_M1_i) ? ~last_q : ARVALID_M1_i;
  assign in_data = (state_q == ST_DATA);

  always_comb begin
    tagged_id                = '0;
    tagged_id[ID_BITS]       = winner;
    tagged_id[ID_BITS-1:0]   = winner ? ARID_M1_i : ARID_M0_i;
    grant_tag                = '0;
    grant_tag[0]             = grant_q;
  end

  // Gated by reset so no master sees an accept that the reset would discard.
  assign ARREADY_M0_o = AXI_RST_i & (state_q == ST_IDLE) & req_any & ~winner;
  assign ARREADY_M1_o = AXI_RST_i & (state_q == ST_IDLE) & req_any &  winner;

  assign ARID_S_o    = arid_q;
  assign ARADDR_S_o  = araddr_q;
  assign ARLEN_S_o   = arlen_q;
  assign ARSIZE_S_o  = arsize_q;
  assign ARBURST_S_o = arburst_q;
  assign ARVALID_S_o = arvalid_q;
  assign ERR_o       = err_q;

  assign rready_g   = grant_q ? RREADY_M1_i : RREADY_M0_i;
  assign RREADY_S_o = in_data & rready_g;
  assign r_hs       = in_data & RVALID_S_i & rready_g;

  always_comb begin
    RID_M0_o    = '0;
    RDATA_M0_o  = '0;
    RRESP_M0_o  = '0;
    RLAST_M0_o  = 1'b0;
    RVALID_M0_o = 1'b0;
    RID_M1_o    = '0;
    RDATA_M1_o  = '0;
    RRESP_M1_o  = '0;
    RLAST_M1_o  = 1'b0;
    RVALID_M1_o = 1'b0;
    if (in_data) begin
      if (grant_q) begin
        RID_M1_o    = RID_S_i[ID_BITS-1:0];
        RDATA_M1_o  = RDATA_S_i;
        RRESP_M1_o  = RRESP_S_i;
        RLAST_M1_o  = RLAST_S_i;
        RVALID_M1_o = RVALID_S_i;
      end else begin
        RID_M0_o    = RID_S_i[ID_BITS-1:0];
        RDATA_M0_o  = RDATA_S_i;
        RRESP_M0_o  = RRESP_S_i;
        RLAST_M0_o  = RLAST_S_i;
        RVALID_M0_o = RVALID_S_i;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    err_d     = err_q;
    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    beat_d    = beat_q;

    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          arid_d    = tagged_id;
          araddr_d  = winner ? ARADDR_M1_i  : ARADDR_M0_i;
          arlen_d   = winner ? ARLEN_M1_i   : ARLEN_M0_i;
          arsize_d  = winner ? ARSIZE_M1_i  : ARSIZE_M0_i;
          arburst_d = winner ? ARBURST_M1_i : ARBURST_M0_i;
          grant_d   = winner;
          beat_d    = '0;
          arvalid_d = 1'b1;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ARREADY_S_i) begin
          arvalid_d = 1'b0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_hs) begin
          beat_d = beat_q + LEN_BITS'(1);
          if (RLAST_S_i) begin
            if (beat_q != arlen_q) begin
              err_d = 1'b1;
            end
            last_d  = grant_q;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Stray beats outside DATA are dropped (RREADY_S_o is low) but flagged.
    if (RVALID_S_i && !in_data) begin
      err_d = 1'b1;
    end
    if (RVALID_S_i && in_data && (RID_S_i[IDS_BITS-1:ID_BITS] != grant_tag)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
    if (!AXI_RST_i) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      grant_q   <= 1'b0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      err_q     <= err_d;
      arvalid_q <= arvalid_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      beat_q    <= beat_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// Testbench for axi_rd_arbiter: directed vector table, hand-written reset and
// stray-beat sequences, then randomized transactions against a round-robin model.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic [3:0]  ARID_M0_i, ARID_M1_i, ARLEN_M0_i, ARLEN_M1_i;
  logic [31:0] ARADDR_M0_i, ARADDR_M1_i;
  logic [2:0]  ARSIZE_M0_i, ARSIZE_M1_i;
  logic [1:0]  ARBURST_M0_i, ARBURST_M1_i;
  logic        ARVALID_M0_i, ARVALID_M1_i, ARREADY_M0_o, ARREADY_M1_o;
  logic [3:0]  RID_M0_o, RID_M1_o;
  logic [31:0] RDATA_M0_o, RDATA_M1_o;
  logic [1:0]  RRESP_M0_o, RRESP_M1_o;
  logic        RLAST_M0_o, RLAST_M1_o, RVALID_M0_o, RVALID_M1_o;
  logic        RREADY_M0_i, RREADY_M1_i;
  logic [7:0]  ARID_S_o;
  logic [31:0] ARADDR_S_o;
  logic [3:0]  ARLEN_S_o;
  logic [2:0]  ARSIZE_S_o;
  logic [1:0]  ARBURST_S_o;
  logic        ARVALID_S_o, ARREADY_S_i;
  logic [7:0]  RID_S_i;
  logic [31:0] RDATA_S_i;
  logic [1:0]  RRESP_S_i;
  logic        RLAST_S_i, RVALID_S_i, RREADY_S_o, ERR_o;

  axi_rd_arbiter dut (
    .AXI_CLK_i(clk), .AXI_RST_i(rst_n),
    .ARID_M0_i(ARID_M0_i), .ARADDR_M0_i(ARADDR_M0_i), .ARLEN_M0_i(ARLEN_M0_i),
    .ARSIZE_M0_i(ARSIZE_M0_i), .ARBURST_M0_i(ARBURST_M0_i), .ARVALID_M0_i(ARVALID_M0_i),
    .ARREADY_M0_o(ARREADY_M0_o),
    .ARID_M1_i(ARID_M1_i), .ARADDR_M1_i(ARADDR_M1_i), .ARLEN_M1_i(ARLEN_M1_i),
    .ARSIZE_M1_i(ARSIZE_M1_i), .ARBURST_M1_i(ARBURST_M1_i), .ARVALID_M1_i(ARVALID_M1_i),
    .ARREADY_M1_o(ARREADY_M1_o),
    .RID_M0_o(RID_M0_o), .RDATA_M0_o(RDATA_M0_o), .RRESP_M0_o(RRESP_M0_o),
    .RLAST_M0_o(RLAST_M0_o), .RVALID_M0_o(RVALID_M0_o), .RREADY_M0_i(RREADY_M0_i),
    .RID_M1_o(RID_M1_o), .RDATA_M1_o(RDATA_M1_o), .RRESP_M1_o(RRESP_M1_o),
    .RLAST_M1_o(RLAST_M1_o), .RVALID_M1_o(RVALID_M1_o), .RREADY_M1_i(RREADY_M1_i),
    .ARID_S_o(ARID_S_o), .ARADDR_S_o(ARADDR_S_o), .ARLEN_S_o(ARLEN_S_o),
    .ARSIZE_S_o(ARSIZE_S_o), .ARBURST_S_o(ARBURST_S_o), .ARVALID_S_o(ARVALID_S_o),
    .ARREADY_S_i(ARREADY_S_i),
    .RID_S_i(RID_S_i), .RDATA_S_i(RDATA_S_i), .RRESP_S_i(RRESP_S_i),
    .RLAST_S_i(RLAST_S_i), .RVALID_S_i(RVALID_S_i), .RREADY_S_o(RREADY_S_o),
    .ERR_o(ERR_o)
  );

  typedef struct {
    bit          req0, req1;
    logic [3:0]  id0, id1;
    logic [31:0] addr0, addr1;
    logic [3:0]  len0, len1;
    int          nb;      // beats the slave returns, RLAST on the final one
    bit          bad;     // slave tags RID with the other master's index
    int          mode;    // 0 random valid/ready, 1 ready toggles 1,0,1,0, 2 always ready
    int          ard;     // slave ARREADY delay in cycles
    bit          exp_w;
    logic [7:0]  exp_arid;
    bit          exp_err;
  } vec_t;

  int   n_chk = 0;
  int   n_err = 0;
  bit   m_last;   // model: master served most recently
  bit   m_err;    // model: sticky error
  vec_t tbl[9];
  vec_t rv_vec;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit r0, bit r1, logic [3:0] i0, logic [3:0] i1, logic [31:0] a,
                              logic [3:0] l0, logic [3:0] l1, int nb, int mode, int ard,
                              bit ew, logic [7:0] earid, bit eerr);
    vec_t v;
    v.req0 = r0; v.req1 = r1; v.id0 = i0; v.id1 = i1;
    v.addr0 = a; v.addr1 = a + 32'h0001_0100;
    v.len0 = l0; v.len1 = l1; v.nb = nb; v.bad = 1'b0; v.mode = mode; v.ard = ard;
    v.exp_w = ew; v.exp_arid = earid; v.exp_err = eerr;
    return v;
  endfunction

  task automatic clear_inputs();
    ARVALID_M0_i = 0; ARVALID_M1_i = 0; ARID_M0_i = 0; ARID_M1_i = 0;
    ARADDR_M0_i = 0; ARADDR_M1_i = 0; ARLEN_M0_i = 0; ARLEN_M1_i = 0;
    ARSIZE_M0_i = 0; ARSIZE_M1_i = 0; ARBURST_M0_i = 0; ARBURST_M1_i = 0;
    RREADY_M0_i = 0; RREADY_M1_i = 0; ARREADY_S_i = 0;
    RID_S_i = 0; RDATA_S_i = 0; RRESP_S_i = 0; RLAST_S_i = 0; RVALID_S_i = 0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_last = 1'b1;
    m_err  = 1'b0;
  endtask

  // Starts 1 time unit after a rising edge with the arbiter idle; ends likewise.
  task automatic run_txn(input vec_t v, input bit use_exp);
    bit          w, rv, rr, e_err, last_beat;
    logic [3:0]  idw, lenw, up;
    logic [31:0] addrw, dat;
    logic [7:0]  earid;
    logic [1:0]  resp;
    int          k, cyc, got;
    w = (v.req0 && v.req1) ? ~m_last : v.req1;
    if (use_exp) w = v.exp_w;
    idw   = w ? v.id1 : v.id0;
    lenw  = w ? v.len1 : v.len0;
    addrw = w ? v.addr1 : v.addr0;
    earid = use_exp ? v.exp_arid : {3'b000, w, idw};
    e_err = m_err;

    ARVALID_M0_i = v.req0; ARID_M0_i = v.id0; ARADDR_M0_i = v.addr0; ARLEN_M0_i = v.len0;
    ARSIZE_M0_i = 3'd2; ARBURST_M0_i = 2'b01;
    ARVALID_M1_i = v.req1; ARID_M1_i = v.id1; ARADDR_M1_i = v.addr1; ARLEN_M1_i = v.len1;
    ARSIZE_M1_i = 3'd1; ARBURST_M1_i = 2'b10;
    #2;
    chk("arready_m0", ARREADY_M0_o, !w);
    chk("arready_m1", ARREADY_M1_o, w);
    @(posedge clk); #1;
    // The winner withdraws and scrambles its fields; the loser keeps requesting.
    if (w) begin
      ARVALID_M1_i = 0; ARADDR_M1_i = ~v.addr1; ARLEN_M1_i = ~v.len1; ARID_M1_i = ~v.id1;
    end else begin
      ARVALID_M0_i = 0; ARADDR_M0_i = ~v.addr0; ARLEN_M0_i = ~v.len0; ARID_M0_i = ~v.id0;
    end

    for (int d = 0; d <= v.ard; d++) begin
      ARREADY_S_i = (d == v.ard);
      #2;
      chk("arvalid_s", ARVALID_S_o, 1);
      chk("arid_s", ARID_S_o, earid);
      chk("araddr_s", ARADDR_S_o, addrw);
      chk("arlen_s", ARLEN_S_o, lenw);
      chk("arsize_s", ARSIZE_S_o, w ? 3'd1 : 3'd2);
      chk("arburst_s", ARBURST_S_o, w ? 2'b10 : 2'b01);
      chk("addr_arready", {ARREADY_M1_o, ARREADY_M0_o}, 2'b00);
      @(posedge clk); #1;
    end
    ARREADY_S_i = 0;

    k = 0; cyc = 0; got = 0;
    up = {3'b000, w ^ v.bad};
    while (k < v.nb && cyc < 400) begin
      rv = (v.mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      rr = (v.mode == 1) ? (cyc % 2 == 0) :
           (v.mode == 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      dat = $urandom;
      resp = 2'($urandom_range(0, 3));
      last_beat = (k == v.nb - 1);
      RVALID_S_i = rv; RDATA_S_i = dat; RRESP_S_i = resp;
      RID_S_i = {up, idw}; RLAST_S_i = last_beat;
      if (w) begin RREADY_M1_i = rr; RREADY_M0_i = 1'($urandom_range(0, 1)); end
      else   begin RREADY_M0_i = rr; RREADY_M1_i = 1'($urandom_range(0, 1)); end
      #2;
      chk("rvalid_g", w ? RVALID_M1_o : RVALID_M0_o, rv);
      chk("rready_s", RREADY_S_o, rr);
      chk("rvalid_other", w ? RVALID_M0_o : RVALID_M1_o, 0);
      chk("rdata_other", w ? RDATA_M0_o : RDATA_M1_o, 0);
      chk("data_arready", {ARREADY_M1_o, ARREADY_M0_o}, 2'b00);
      if (rv) begin
        chk("rdata_g", w ? RDATA_M1_o : RDATA_M0_o, dat);
        chk("rid_g", w ? RID_M1_o : RID_M0_o, idw);
        chk("rlast_g", w ? RLAST_M1_o : RLAST_M0_o, last_beat);
        chk("rresp_g", w ? RRESP_M1_o : RRESP_M0_o, resp);
        if (v.bad) e_err = 1'b1;
      end
      if ((w ? RVALID_M1_o : RVALID_M0_o) && rr) got++;
      if (rv && rr) begin
        if (last_beat && (v.nb - 1) != int'(lenw)) e_err = 1'b1;
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    RVALID_S_i = 0; RLAST_S_i = 0; RREADY_M0_i = 0; RREADY_M1_i = 0;
    ARVALID_M0_i = 0; ARVALID_M1_i = 0;
    if (use_exp) e_err = v.exp_err;
    chk("beats_delivered", got, v.nb);
    chk("err_after_txn", ERR_o, e_err);
    chk("arvalid_s_idle", ARVALID_S_o, 0);
    m_err  = e_err;
    m_last = w;
  endtask

  initial begin
    tbl[0] = mk(1, 0, 4'h3, 4'h0, 32'h1000, 4'd3, 4'd0, 4, 1, 0, 0, 8'h03, 0);
    tbl[1] = mk(1, 1, 4'h5, 4'h7, 32'h2000, 4'd2, 4'd1, 2, 2, 1, 1, 8'h17, 0);
    tbl[2] = mk(1, 1, 4'h5, 4'h7, 32'h2040, 4'd2, 4'd1, 3, 2, 0, 0, 8'h05, 0);
    tbl[3] = mk(1, 1, 4'h5, 4'h7, 32'h2080, 4'd2, 4'd1, 2, 2, 2, 1, 8'h17, 0);
    tbl[4] = mk(0, 1, 4'h0, 4'h2, 32'h3000, 4'd0, 4'd1, 2, 0, 0, 1, 8'h12, 0);
    tbl[5] = mk(1, 0, 4'hA, 4'h0, 32'h4000, 4'd0, 4'd0, 1, 0, 1, 0, 8'h0A, 0);
    tbl[6] = mk(1, 0, 4'h1, 4'h0, 32'h5000, 4'd3, 4'd0, 3, 2, 0, 0, 8'h01, 1);
    tbl[7] = mk(1, 1, 4'h4, 4'h9, 32'h6000, 4'd1, 4'd2, 3, 0, 0, 1, 8'h19, 1);
    tbl[8] = mk(1, 1, 4'h6, 4'h3, 32'h7000, 4'd1, 4'd1, 2, 2, 0, 0, 8'h06, 0);

    rst_n = 1'b0;
    clear_inputs();
    ARVALID_M0_i = 1; ARVALID_M1_i = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", {ARREADY_M1_o, ARREADY_M0_o}, 2'b00);
    chk("rst_arvalid_s", ARVALID_S_o, 0);
    chk("rst_arid_s", ARID_S_o, 0);
    chk("rst_rvalid", {RVALID_M1_o, RVALID_M0_o}, 2'b00);
    chk("rst_rready_s", RREADY_S_o, 0);
    chk("rst_err", ERR_o, 0);
    reset_dut();

    for (int i = 0; i < 8; i++) run_txn(tbl[i], 1'b1);

    // Reset in the middle of a burst, with ERR_o already set.
    ARVALID_M0_i = 1; ARID_M0_i = 4'h6; ARLEN_M0_i = 4'd3; ARADDR_M0_i = 32'h9000;
    #2 chk("mid_arready_m0", ARREADY_M0_o, 1);
    @(posedge clk); #1;
    ARVALID_M0_i = 0; ARREADY_S_i = 1;
    @(posedge clk); #1;
    ARREADY_S_i = 0; RVALID_S_i = 1; RID_S_i = 8'h06; RDATA_S_i = 32'hCAFE_0001;
    ARVALID_M0_i = 1; ARVALID_M1_i = 1;
    #2 chk("mid_rvalid_m0", RVALID_M0_o, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_arvalid_s", ARVALID_S_o, 0);
    chk("abort_arid_s", ARID_S_o, 0);
    chk("abort_rvalid", {RVALID_M1_o, RVALID_M0_o}, 2'b00);
    chk("abort_err", ERR_o, 0);
    chk("abort_arready", {ARREADY_M1_o, ARREADY_M0_o}, 2'b00);
    reset_dut();
    run_txn(tbl[8], 1'b1);

    // Stray beat while idle: dropped and flagged, later traffic still completes.
    RVALID_S_i = 1; RLAST_S_i = 1; RREADY_M0_i = 1; RREADY_M1_i = 1;
    #2;
    chk("stray_rready_s", RREADY_S_o, 0);
    chk("stray_rvalid", {RVALID_M1_o, RVALID_M0_o}, 2'b00);
    @(posedge clk); #1;
    RVALID_S_i = 0; RLAST_S_i = 0; RREADY_M0_i = 0; RREADY_M1_i = 0;
    #1 chk("stray_err", ERR_o, 1);
    m_err = 1'b1;
    run_txn(mk(0, 1, 4'h0, 4'hC, 32'hA000, 4'd0, 4'd2, 3, 0, 1, 0, 8'h00, 0), 1'b0);
    reset_dut();

    for (int t = 0; t < 40; t++) begin
      int  r, nbsel;
      bit  w;
      logic [3:0] lw;
      r = $urandom_range(1, 3);
      rv_vec = mk(r[0], r[1], 4'($urandom), 4'($urandom), $urandom,
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1, 0,
                  $urandom_range(0, 2), 0, 8'h00, 0);
      w  = (rv_vec.req0 && rv_vec.req1) ? ~m_last : rv_vec.req1;
      lw = w ? rv_vec.len1 : rv_vec.len0;
      nbsel = $urandom_range(0, 7);
      rv_vec.nb = int'(lw) + 1 + ((nbsel == 0) ? 1 : 0) - ((nbsel == 1 && lw != 0) ? 1 : 0);
      rv_vec.bad = ($urandom_range(0, 9) == 0);
      rv_vec.mode = $urandom_range(0, 2);
      run_txn(rv_vec, 1'b0);
      if (m_err) reset_dut();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
